// File: rtl/check_collision.sv
// rtl/check_collision.sv - one-pixel step collision check against the fixed maze, plus free-running clock divider
module check_collision #(
  parameter int TILE_SHIFT = 4,
  parameter int SPRITE     = 16,
  parameter int MAP_COLS   = 40,
  parameter int MAP_ROWS   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  PacX,
  input  logic [8:0]  PacY,
  input  logic [1:0]  state,
  output logic        result,
  output logic [31:0] clkdiv
);

  localparam logic [10:0] XMAX  = 11'(640 - SPRITE);
  localparam logic [9:0]  YMAX  = 10'(480 - SPRITE);
  localparam logic [10:0] XSPAN = 11'(SPRITE - 1);
  localparam logic [9:0]  YSPAN = 10'(SPRITE - 1);

  function automatic logic is_wall(input logic [6:0] c, input logic [5:0] r);
    return (r == 6'd0) || (r == 6'(MAP_ROWS - 1)) ||
           (c == 7'd0) || (c == 7'(MAP_COLS - 1)) ||
           ((c[1:0] == 2'd2) && (r[1:0] == 2'd2));
  endfunction

  logic [10:0] nx;
  logic [9:0]  ny;
  logic        under;
  logic [6:0]  col_l, col_r;
  logic [5:0]  row_t, row_b;
  logic        blocked;

  // Candidate is one bit wider than the port so edge overshoot is visible
  always_comb begin
    nx    = {1'b0, PacX};
    ny    = {1'b0, PacY};
    under = 1'b0;
    unique case (state)
      2'b00: begin
        under = (PacY == 9'd0);
        ny    = {1'b0, PacY} - 10'd1;
      end
      2'b01: ny = {1'b0, PacY} + 10'd1;
      2'b10: begin
        under = (PacX == 10'd0);
        nx    = {1'b0, PacX} - 11'd1;
      end
      2'b11: nx = {1'b0, PacX} + 11'd1;
    endcase
  end

  always_comb begin
    col_l = 7'(nx >> TILE_SHIFT);
    col_r = 7'((nx + XSPAN) >> TILE_SHIFT);
    row_t = 6'(ny >> TILE_SHIFT);
    row_b = 6'((ny + YSPAN) >> TILE_SHIFT);
    blocked = under || (nx > XMAX) || (ny > YMAX) ||
              is_wall(col_l, row_t) || is_wall(col_r, row_t) ||
              is_wall(col_l, row_b) || is_wall(col_r, row_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 1'b0;
      clkdiv <= 32'd0;
    end else begin
      result <= ~blocked;
      clkdiv <= clkdiv + 32'd1;
    end
  end

endmodule

// File: tb/tb_check_collision.sv
// tb/tb_check_collision.sv - randomized and directed bench for check_collision
module tb_check_collision;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  PacX;
  logic [8:0]  PacY;
  logic [1:0]  state;
  logic        result;
  logic [31:0] clkdiv;

  int total = 0;
  int bad   = 0;

  check_collision dut (
    .clk(clk), .rst(rst), .PacX(PacX), .PacY(PacY),
    .state(state), .result(result), .clkdiv(clkdiv)
  );

  always #5 clk = ~clk;

  function automatic bit tile_wall(int c, int r);
    return (r == 0) || (r == 29) || (c == 0) || (c == 39) ||
           ((c % 4 == 2) && (r % 4 == 2));
  endfunction

  // Reference: move the box, reject if it leaves the screen, else test its corner tiles
  function automatic bit model_free(int x, int y, int s);
    int nx, ny;
    nx = x;
    ny = y;
    case (s)
      0: ny = y - 1;
      1: ny = y + 1;
      2: nx = x - 1;
      default: nx = x + 1;
    endcase
    if (nx < 0 || ny < 0 || nx + 16 > 640 || ny + 16 > 480) return 1'b0;
    for (int dx = 0; dx < 16; dx += 15)
      for (int dy = 0; dy < 16; dy += 15)
        if (tile_wall((nx + dx) / 16, (ny + dy) / 16)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rand_vec();
    if ($urandom_range(0, 3) == 0) PacX = 10'($urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(615, 639));
    else PacX = 10'($urandom_range(0, 639));
    if ($urandom_range(0, 3) == 0) PacY = 9'($urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(455, 479));
    else PacY = 9'($urandom_range(0, 479));
    state = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    int first_rise;
    first_rise = -1;
    #12;
    total++;
    if (result !== 1'b0) begin
      bad++;
      $display("FAIL reset_result: got %b want 0", result);
    end
    total++;
    if (clkdiv !== 32'd0) begin
      bad++;
      $display("FAIL reset_clkdiv: got %0d want 0", clkdiv);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (first_rise < 0 && clkdiv[9]) first_rise = i;
    end
    total++;
    if (clkdiv !== 32'd1000) begin
      bad++;
      $display("FAIL clkdiv_1000: got %0d want 1000", clkdiv);
    end
    total++;
    if (first_rise != 512) begin
      bad++;
      $display("FAIL clkdiv_bit9_rise: got %0d want 512", first_rise);
    end
  endtask

  task automatic test_directed();
    int  xs[9]  = '{320, 320, 80, 80, 16, 320, 0,   624, 320};
    int  ys[9]  = '{240, 240, 96, 96, 240, 16, 240, 240, 464};
    int  ss[9]  = '{3,   0,   3,  2,  2,   0,  2,   3,   1};
    bit  exp[9] = '{1,   1,   0,  1,  0,   0,  0,   0,   0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      PacX  = 10'(xs[i]);
      PacY  = 9'(ys[i]);
      state = 2'(ss[i]);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (result !== exp[i]) begin
        bad++;
        $display("FAIL directed_%0d x=%0d y=%0d s=%0d: got %b want %b", i, xs[i], ys[i], ss[i], result, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    bit exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rand_vec();
      exp = model_free(int'(PacX), int'(PacY), int'(state));
      @(posedge clk);
      @(negedge clk);
      total++;
      if (result !== exp) begin
        bad++;
        $display("FAIL random x=%0d y=%0d s=%0d: got %b want %b", PacX, PacY, state, result, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp;
    @(negedge clk);
    rand_vec();
    for (int i = 0; i < 60; i++) begin
      exp = model_free(int'(PacX), int'(PacY), int'(state));
      @(posedge clk);
      @(negedge clk);
      total++;
      if (result !== exp) begin
        bad++;
        $display("FAIL b2b_follow %0d: got %b want %b", i, result, exp);
      end
      rand_vec();
      #1;
      total++;
      if (result !== exp) begin
        bad++;
        $display("FAIL b2b_hold %0d: got %b want %b", i, result, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    PacX  = 10'd320;
    PacY  = 9'd240;
    state = 2'd3;
    @(posedge clk);
    #2;
    total++;
    if (result !== 1'b1) begin
      bad++;
      $display("FAIL async_pre: got %b want 1", result);
    end
    rst = 1'b1;
    #1;
    total++;
    if (result !== 1'b0 || clkdiv !== 32'd0) begin
      bad++;
      $display("FAIL async_assert: got result=%b clkdiv=%0d want 0/0", result, clkdiv);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (result !== 1'b0 || clkdiv !== 32'd0) begin
      bad++;
      $display("FAIL async_hold: got result=%b clkdiv=%0d want 0/0", result, clkdiv);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (result !== 1'b1 || clkdiv !== 32'd1) begin
      bad++;
      $display("FAIL async_resume: got result=%b clkdiv=%0d want 1/1", result, clkdiv);
    end
  endtask

  initial begin
    rst   = 1'b1;
    PacX  = 10'd320;
    PacY  = 9'd240;
    state = 2'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
